fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned     XLEN        = 32;
    localparam int unsigned     FETCH_DEPTH = 4;
    localparam logic [XLEN-1:0] RESET_PC    = 32'd0;

    typedef enum logic {
        StRun,
        StFlush
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with flush; one push and one pop per cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word-address requests, in-order responses queued for decode,
// redirects and resets drop responses still owed by memory.
module fetch_unit #(
    parameter int unsigned                 DEPTH    = cpu_pkg::FETCH_DEPTH,
    parameter logic [cpu_pkg::XLEN-1:0]    RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [cpu_pkg::XLEN-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [cpu_pkg::XLEN-1:0] imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [cpu_pkg::XLEN-1:0] redirect_addr,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [cpu_pkg::XLEN-1:0] dec_instr,
    output logic [cpu_pkg::XLEN-1:0] dec_pc4
);

    import cpu_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = 2 * XLEN;

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_cnt_q;
    logic [SW-1:0]   stale_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   head_data;

    logic            req_fire;
    logic            rsp_stale;
    logic            rsp_live;
    logic            rsp_keep;
    logic            pop;
    logic [CW-1:0]   redirect_drop;
    logic [SW-1:0]   owed;

    always_comb begin
        imem_req_valid = !rst && !redirect_valid &&
                         ((SW'(fifo_count) + SW'(outstanding_q)) < SW'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses owed from before a reset are the oldest in flight, so they come first.
        rsp_stale      = imem_rsp_valid && (stale_q != '0);
        rsp_live       = imem_rsp_valid && (stale_q == '0) && (outstanding_q != '0);
        rsp_keep       = rsp_live && (state_q == StRun) && !redirect_valid;
        dec_valid      = !rst && !fifo_empty && !redirect_valid;
        pop            = dec_valid && dec_ready;
        redirect_drop  = outstanding_q - CW'(rsp_live);
        owed           = stale_q + SW'(outstanding_q);
    end

    assign imem_req_addr = pc_q;
    assign dec_instr     = (rst || fifo_empty) ? '0 : head_data[EW-1:XLEN];
    assign dec_pc4       = (rst || fifo_empty) ? '0 : head_data[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            // Memory is not reset with us; remember how many answers are still coming.
            stale_q       <= owed - SW'(imem_rsp_valid && (owed != '0));
        end else begin
            stale_q       <= stale_q - SW'(rsp_stale);
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_live);
            if (redirect_valid) begin
                pc_q       <= redirect_addr;
                rsp_pc_q   <= redirect_addr;
                drop_cnt_q <= redirect_drop;
                state_q    <= (redirect_drop != '0) ? StFlush : StRun;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + XLEN'(1);
                end
                if (rsp_keep) begin
                    rsp_pc_q <= rsp_pc_q + XLEN'(1);
                end
                if (state_q == StFlush && rsp_live) begin
                    drop_cnt_q <= drop_cnt_q - 1'b1;
                    if (drop_cnt_q == CW'(1)) begin
                        state_q <= StRun;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (rsp_keep),
        .push_data({imem_rsp_data, rsp_pc_q + XLEN'(1)}),
        .pop      (pop),
        .head_data(head_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    unexpected_rsp_a: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0 || stale_q != '0))
        else $error("fetch_unit: response with no request outstanding");

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        rsp_keep |-> (!fifo_full || pop))
        else $error("fetch_unit: response with no free queue slot");

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench: memory model with programmable latency, expected fetch stream in a queue.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc4;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc4       (dec_pc4)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = -1;
    int          n_req = 0;
    int          base;
    int          found;
    int          found_at;
    logic        last_pop;
    logic [31:0] model_pc;
    int          pipe_due[$];
    logic [31:0] pipe_addr[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Drive this cycle's memory response, then sample DUT outputs and update the model.
    task automatic cyc_begin();
        logic [31:0] want;
        int          due;
        if (pipe_due.size() != 0 && pipe_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pipe_addr[0]);
            pipe_due.delete(0);
            pipe_addr.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        last_pop = 1'b0;
        if (rst) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            if (redirect_valid) begin
                check_eq("no_req_in_redirect", imem_req_valid, 1'b0);
                exp_q.delete();
            end
            if (dec_valid && dec_ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check_eq("dec_instr", dec_instr, instr_of(want));
                check_eq("dec_pc4", dec_pc4, want + 32'd1);
                last_pop = 1'b1;
            end
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, model_pc);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pipe_due.push_back(due);
                pipe_addr.push_back(model_pc);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd1;
                n_req++;
            end
            if (redirect_valid) model_pc = redirect_addr;
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        cyc_begin();
        cyc_end();
    endtask

    task automatic check_reset_outs();
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_dec_valid", dec_valid, 1'b0);
        check_eq("rst_dec_instr", dec_instr, 32'd0);
        check_eq("rst_dec_pc4", dec_pc4, 32'd0);
    endtask

    // Wait for the next pop and return how many cycles it took.
    task automatic wait_pop(input int limit);
        found    = 0;
        found_at = -1;
        for (int i = 0; i < limit && found == 0; i++) begin
            cyc_begin();
            if (last_pop) begin
                found    = 1;
                found_at = i;
            end
            if (found == 0) cyc_end();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        dec_ready      = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_pc       = RESET_PC;
        @(negedge clk);

        // Reset, then 1-cycle memory: first request RESET_PC, first dec_valid two cycles later.
        repeat (2) begin
            cyc_begin();
            check_reset_outs();
            cyc_end();
        end
        rst = 1'b0;
        cyc_begin();
        check_eq("first_req_valid", imem_req_valid, 1'b1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
        cyc_end();
        cyc_begin();
        check_eq("c1_dec_valid", dec_valid, 1'b0);
        cyc_end();
        cyc_begin();
        check_eq("c2_dec_valid", dec_valid, 1'b1);
        check_eq("c2_dec_pc4", dec_pc4, RESET_PC + 32'd1);
        cyc_end();
        repeat (8) step();

        // Decode stalled for 10 cycles: exactly DEPTH requests, then none until a pop.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        dec_ready = 1'b0;
        base      = n_req;
        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            if (i >= 4) check_eq("stall_req_valid", imem_req_valid, 1'b0);
            cyc_end();
        end
        check_eq("stall_req_count", n_req - base, DEPTH);
        dec_ready = 1'b1;
        cyc_begin();
        check_eq("pop_cycle_dec_valid", dec_valid, 1'b1);
        check_eq("pop_cycle_req_valid", imem_req_valid, 1'b0);
        cyc_end();
        cyc_begin();
        check_eq("after_pop_req_valid", imem_req_valid, 1'b1);
        cyc_end();
        repeat (6) step();

        // Redirect near the top of the address space exercises the wrap to zero.
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();

        // Memory back-pressure: address and valid hold, no increment.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc_begin();
            check_eq("hold_addr", imem_req_addr, model_pc);
            check_eq("hold_valid", imem_req_valid, 1'b1);
            cyc_end();
        end
        imem_req_ready = 1'b1;
        repeat (4) step();

        // Redirect coincident with a response and dec_ready: no pop, queue empty after.
        dec_ready = 1'b0;
        repeat (2) step();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        cyc_begin();
        check_eq("rdr_no_pop", dec_valid, 1'b0);
        cyc_end();
        redirect_valid = 1'b0;
        cyc_begin();
        check_eq("rdr_empty_next", dec_valid, 1'b0);
        check_eq("rdr_req_valid", imem_req_valid, 1'b1);
        check_eq("rdr_req_addr", imem_req_addr, 32'h100);
        cyc_end();
        repeat (6) step();

        // 3-cycle memory, redirect to 0x40 with two requests outstanding.
        lat            = 3;
        imem_req_ready = 1'b0;
        repeat (8) step();
        imem_req_ready = 1'b1;
        repeat (2) step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_pop(20);
        check_eq("rdr40_seen", found, 1);
        check_eq("rdr40_latency", found_at, 4);
        check_eq("rdr40_pc4", dec_pc4, 32'h41);
        check_eq("rdr40_instr", dec_instr, instr_of(32'h40));
        cyc_end();
        repeat (6) step();

        // Reset with two requests outstanding: their late responses must be ignored.
        imem_req_ready = 1'b0;
        repeat (8) step();
        imem_req_ready = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        cyc_begin();
        check_reset_outs();
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        check_eq("post_rst_req_valid", imem_req_valid, 1'b1);
        check_eq("post_rst_req_addr", imem_req_addr, RESET_PC);
        cyc_end();
        wait_pop(20);
        check_eq("post_rst_seen", found, 1);
        check_eq("post_rst_pc4", dec_pc4, RESET_PC + 32'd1);
        check_eq("post_rst_instr", dec_instr, instr_of(RESET_PC));
        cyc_end();
        repeat (6) step();

        // Drain: everything requested since the last flush must have been delivered.
        imem_req_ready = 1'b0;
        repeat (12) step();
        check_eq("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
